alu_24bit: RTL and testbench

- 24-bit integer ALU for the single-cycle 24-bit CPU datapath.
- Computes AND/OR/ADD/SUB/SLT/XOR/NOR on two 24-bit operands, with optional per-operand inversion.
- Result and flags (zero, overflow, carry-out) are registered: one cycle latency.
- Sits between the register file / immediate mux and the writeback / branch-compare logic.

---
 rtl/alu_24bit_pkg.sv | 15 +
 rtl/alu_24bit_1bit.sv | 41 ++++
 rtl/alu_24bit.sv | 104 ++++++++++
 tb/tb_alu_24bit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_24bit_pkg.sv
// Shared width, shift-amount width and opcode encodings for the 24-bit ALU.
package alu_24bit_pkg;
   localparam int WIDTH   = 24;
   localparam int OP_W    = 3;
   localparam int SHAMT_W = 5;

   localparam logic [OP_W-1:0] OP_AND = 3'b000;
   localparam logic [OP_W-1:0] OP_OR  = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_SLT = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_NOR = 3'b101;
   localparam logic [OP_W-1:0] OP_SLL = 3'b110;
   localparam logic [OP_W-1:0] OP_SRL = 3'b111;
endpackage

// File: rtl/alu_24bit_1bit.sv
// One bit-slice of the ripple ALU: operand inversion, full adder and op mux.
// Opcodes 110/111 yield 0 here; the top substitutes the shifter when enabled.
module alu_1bit
   import alu_24bit_pkg::*;
(
   input  logic            a,
   input  logic            b,
   input  logic            ainv,
   input  logic            binv,
   input  logic            cin,
   input  logic            less,
   input  logic [OP_W-1:0] op,
   output logic            res,
   output logic            cout,
   output logic            set
);
   logic a_eff;
   logic b_eff;
   logic sum;

   always_comb begin
      a_eff = a ^ ainv;
      b_eff = b ^ binv;
      sum   = a_eff ^ b_eff ^ cin;
      cout  = (a_eff & b_eff) | (cin & (a_eff ^ b_eff));
      set   = sum;
   end

   always_comb begin
      res = 1'b0;
      case (op)
         OP_AND:  res = a_eff & b_eff;
         OP_OR:   res = a_eff | b_eff;
         OP_ADD:  res = sum;
         OP_SLT:  res = less;
         OP_XOR:  res = a_eff ^ b_eff;
         OP_NOR:  res = ~(a_eff | b_eff);
         default: res = 1'b0;
      endcase
   end
endmodule

// File: rtl/alu_24bit.sv
// 24-bit registered ALU built from a ripple chain of alu_1bit slices.
// Define ALU_SHIFT_EN to turn opcodes 110/111 into SLL/SRL; otherwise they give 0.
module alu_24bit
   import alu_24bit_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [W-1:0]    A,
   input  logic [W-1:0]    B,
   input  logic            AInvert,
   input  logic            BInvert,
   input  logic [OP_W-1:0] Operation,
   output logic            zero,
   output logic [W-1:0]    Result,
   output logic            overflow,
   output logic            COUT
);
   logic [W:0]   carry;
   logic [W-1:0] cell_res;
   logic [W-1:0] cell_set;
   logic         add_ovf;
   logic         less0;
   logic         unused_set_bits;

   logic [W-1:0] result_d, result_q;
   logic         zero_d, zero_q;
   logic         ovf_d, ovf_q;
   logic         cout_d, cout_q;

   assign carry[0] = BInvert;

   for (genvar i = 0; i < W; i++) begin : g_bit
      alu_1bit u_bit (
         .a    (A[i]),
         .b    (B[i]),
         .ainv (AInvert),
         .binv (BInvert),
         .cin  (carry[i]),
         .less ((i == 0) ? less0 : 1'b0),
         .op   (Operation),
         .res  (cell_res[i]),
         .cout (carry[i+1]),
         .set  (cell_set[i])
      );
   end

   // Signed overflow compares carry into and out of the MSB; SLT corrects the sign with it.
   assign add_ovf         = carry[W] ^ carry[W-1];
   assign less0           = cell_set[W-1] ^ add_ovf;
   assign unused_set_bits = &{1'b0, cell_set[W-2:0]};

`ifdef ALU_SHIFT_EN
   logic [W-1:0]       a_prep;
   logic [W-1:0]       b_prep;
   logic [SHAMT_W-1:0] shamt;
   logic               shamt_big;

   always_comb begin
      a_prep    = AInvert ? ~A : A;
      b_prep    = BInvert ? ~B : B;
      shamt     = b_prep[SHAMT_W-1:0];
      shamt_big = (int'(shamt) >= W);
   end
`endif

   always_comb begin
      result_d = cell_res;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      case (Operation)
         OP_ADD, OP_SLT: begin
            cout_d = carry[W];
            ovf_d  = add_ovf;
         end
`ifdef ALU_SHIFT_EN
         OP_SLL:  result_d = shamt_big ? '0 : (a_prep << shamt);
         OP_SRL:  result_d = shamt_big ? '0 : (a_prep >> shamt);
`endif
         default: ;
      endcase
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
      end
   end

   assign Result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
   assign COUT     = cout_q;
endmodule

// File: tb/tb_alu_24bit.sv
// Directed-vector bench for alu_24bit with hand-computed expected results.
`timescale 1ns/1ps
module tb_alu_24bit;
   localparam int W  = 24;
   localparam int EW = W + 3;

   logic         clk;
   logic         reset;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         AInvert;
   logic         BInvert;
   logic [2:0]   Operation;
   logic         zero;
   logic [W-1:0] Result;
   logic         overflow;
   logic         COUT;

   int errors;
   int checks;
   logic [EW-1:0] exp_q[$];

   alu_24bit dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .AInvert   (AInvert),
      .BInvert   (BInvert),
      .Operation (Operation),
      .zero      (zero),
      .Result    (Result),
      .overflow  (overflow),
      .COUT      (COUT)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, ".result"},   {8'd0, Result}, {8'd0, e[W-1:0]});
         check({tag, ".cout"},     {31'd0, COUT},     {31'd0, e[W]});
         check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e[W+1]});
         check({tag, ".zero"},     {31'd0, zero},     {31'd0, e[W+2]});
      end
   endtask

   // driver: apply at negedge, expect on the following posedge
   task automatic drive_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ainv, input logic binv, input logic [2:0] op,
                           input logic [W-1:0] exp_res, input logic exp_cout, input logic exp_ovf);
      @(negedge clk);
      A = a; B = b; AInvert = ainv; BInvert = binv; Operation = op;
      exp_q.push_back({(exp_res == '0), exp_ovf, exp_cout, exp_res});
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   logic [W-1:0] sll_exp;
   logic [W-1:0] srl_exp;

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      A = '0; B = '0; AInvert = 1'b0; BInvert = 1'b0; Operation = 3'b000;
`ifdef ALU_SHIFT_EN
      sll_exp = 24'h000010;
      srl_exp = 24'h080000;
`else
      sll_exp = 24'h000000;
      srl_exp = 24'h000000;
`endif
      #12;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 24'h0});
      check_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      drive_op("xor",      24'h000000, 24'h000001, 0, 0, 3'b100, 24'h000001, 0, 0);
      drive_op("add_wrap", 24'hFFFFFF, 24'h000001, 0, 0, 3'b010, 24'h000000, 1, 0);
      drive_op("add_ovf",  24'h7FFFFF, 24'h000001, 0, 0, 3'b010, 24'h800000, 0, 1);
      drive_op("sub",      24'h000005, 24'h000007, 0, 1, 3'b010, 24'hFFFFFE, 0, 0);
      drive_op("slt_lt",   24'h000005, 24'h000007, 0, 1, 3'b011, 24'h000001, 0, 0);
      drive_op("slt_ge",   24'h000007, 24'h000005, 0, 1, 3'b011, 24'h000000, 1, 0);
      drive_op("sub_ovf",  24'h800000, 24'h000001, 0, 1, 3'b010, 24'h7FFFFF, 1, 1);
      drive_op("slt_ovf",  24'h800000, 24'h000001, 0, 1, 3'b011, 24'h000001, 1, 1);
      drive_op("and_inv",  24'h0F0F0F, 24'h00FF00, 1, 1, 3'b000, 24'hF000F0, 0, 0);
      drive_op("nor",      24'h0F0F0F, 24'h00FF00, 0, 0, 3'b101, 24'hF000F0, 0, 0);
      drive_op("or",       24'h123400, 24'h000056, 0, 0, 3'b001, 24'h123456, 0, 0);
      drive_op("op110",    24'h000001, 24'h000004, 0, 0, 3'b110, sll_exp,    0, 0);
      drive_op("op110_24", 24'h000001, 24'h000018, 0, 0, 3'b110, 24'h000000, 0, 0);
      drive_op("op111",    24'h800000, 24'h000004, 0, 0, 3'b111, srl_exp,    0, 0);
      drive_op("op111_31", 24'hFFFFFF, 24'h00001F, 0, 0, 3'b111, 24'h000000, 0, 0);

      // reset asserted between edges clears outputs at once
      drive_op("pre_rst",  24'h000005, 24'h000007, 0, 0, 3'b010, 24'h00000C, 0, 0);
      @(negedge clk);
      A = 24'h000001; B = 24'h000002;
      #2 reset = 1'b1;
      #1;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 24'h0});
      check_outputs("mid_rst");
      @(posedge clk);
      #1;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 24'h0});
      check_outputs("rst_held");
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 1'b0, 24'h000003});
      @(posedge clk);
      #1;
      check_outputs("post_rst");

      check("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
